// File: rtl/ball_bouncer_pkg.sv
// ball_bouncer_pkg
//  Shared types for the ball_bouncer sprite engine:
//   - upd_state_t : once-per-frame updater FSM states (IDLE/UPDATE/COMMIT)
//   - axis_res_t  : one-axis reflect result {pos, vel, hit}
//   - sat_add16   : saturating 16-bit accumulate helper (hit counter)
//  The reflect-result fields are sized by BB_CW/BB_VW. The top-level CW/VW
//  parameters default to these widths. Raise them here before building
//  wider coordinates or velocities.
package ball_bouncer_pkg;

    localparam int BB_CW = 11;
    localparam int BB_VW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } upd_state_t;

    typedef struct packed {
        logic [BB_CW-1:0]        pos;
        logic signed [BB_VW-1:0] vel;
        logic                    hit;
    } axis_res_t;

    // Add a 0..2 increment to a 16-bit count, sticking at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step
//  Combinational single-axis move + wall reflect for one ball.
//  The velocity is optionally negated first (pending reverse). It is then
//  added to the position, signed at CW+1 bits. A result past LIM is clamped
//  to LIM, and a negative result is clamped to 0. Both cases flip the
//  velocity and flag a hit.
//  Ports:
//   pos  in   CW       current position
//   vel  in   VW       current signed velocity
//   neg  in   1        negate velocity before stepping
//   res  out  struct   {new pos, new vel, reflection happened}
module ball_axis_step
    import ball_bouncer_pkg::*;
#(
    parameter int CW  = BB_CW,
    parameter int VW  = BB_VW,
    parameter int LIM = 624
) (
    input  logic [CW-1:0]        pos,
    input  logic signed [VW-1:0] vel,
    input  logic                 neg,
    output axis_res_t            res
);

    localparam logic signed [CW:0] LIM_S = (CW+1)'(LIM);

    logic signed [VW-1:0] v_s;
    logic signed [CW:0]   n_s;

    // Step and reflect; the sign bit of n_s marks a move past the low wall.
    always_comb begin
        res = '0;
        if (neg) begin
            v_s = -vel;
        end else begin
            v_s = vel;
        end
        n_s = $signed({1'b0, pos}) + $signed({{(CW+1-VW){v_s[VW-1]}}, v_s});
        if (n_s > LIM_S) begin
            res.pos = BB_CW'(LIM_S[CW-1:0]);
            res.vel = BB_VW'(-v_s);
            res.hit = 1'b1;
        end else if (n_s[CW]) begin
            res.pos = '0;
            res.vel = BB_VW'(-v_s);
            res.hit = 1'b1;
        end else begin
            res.pos = BB_CW'(n_s[CW-1:0]);
            res.vel = BB_VW'(v_s);
            res.hit = 1'b0;
        end
    end

endmodule

// File: rtl/ball_bouncer.sv
// ball_bouncer
//  Multi-ball sprite engine: N_BALLS balls of BALL_W x BALL_H bounce inside an
//  X_RES x Y_RES frame. On each frame tick (hcnt==0 && vcnt==0), the updater
//  steps ball 0..N_BALLS-1, one per clock, on working registers. It then
//  copies all positions to the display registers in one COMMIT clock, so the
//  drawn picture never shows a half-updated frame.
//  Ports:
//   clk        in   1      pixel clock
//   rst        in   1      asynchronous reset, active-high
//   i_hcnt     in   CW     horizontal pixel counter
//   i_vcnt     in   CW     vertical pixel counter
//   i_reverse  in   1      pulse: negate all velocities at the next update
//   i_pause    in   1      level: frame ticks are ignored while high
//   o_draw     out  1      pixel (previous clk) lies in some ball
//   o_ball_idx out  IDXW   lowest-index ball hit, 0 if none
//   o_busy     out  1      updater not IDLE
//   o_bounce   out  1      one-clk pulse when a committed update reflected
//   o_hits     out  16     only with BALL_BOUNCER_HITCNT_EN: saturating count
//                          of reflections (X and Y counted separately)
module ball_bouncer
    import ball_bouncer_pkg::*;
#(
    parameter int N_BALLS = 4,
    parameter int CW      = BB_CW,
    parameter int VW      = BB_VW,
    parameter int X_RES   = 640,
    parameter int Y_RES   = 480,
    parameter int BALL_W  = 16,
    parameter int BALL_H  = 16,
    parameter int DX0     = 1,
    parameter int DY0     = 1,
    parameter int SX      = 100,
    parameter int SY      = 60,
    localparam int IDXW   = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW-1:0]   i_hcnt,
    input  logic [CW-1:0]   i_vcnt,
    input  logic            i_reverse,
    input  logic            i_pause,
    output logic            o_draw,
    output logic [IDXW-1:0] o_ball_idx,
    output logic            o_busy,
    output logic            o_bounce
`ifdef BALL_BOUNCER_HITCNT_EN
   ,output logic [15:0]     o_hits
`endif
);

    localparam int LIM_X = X_RES - BALL_W;
    localparam int LIM_Y = Y_RES - BALL_H;

    logic [CW-1:0]        wpos_x_r [N_BALLS];
    logic [CW-1:0]        wpos_y_r [N_BALLS];
    logic signed [VW-1:0] wvel_x_r [N_BALLS];
    logic signed [VW-1:0] wvel_y_r [N_BALLS];
    logic [CW-1:0]        dpos_x_r [N_BALLS];
    logic [CW-1:0]        dpos_y_r [N_BALLS];

    upd_state_t      state_r, state_s;
    logic [IDXW-1:0] idx_r;
    logic            rev_pend_r;
    logic            bounce_acc_r;
    logic            bounce_r;
    logic            busy_r;
    logic            draw_r;
    logic [IDXW-1:0] ball_idx_r;

    logic            tick_s;
    logic            last_s;
    axis_res_t       step_x_s, step_y_s;
    logic [N_BALLS-1:0] hit_s;
    logic            hit_any_s;
    logic [IDXW-1:0] hit_idx_s;

    assign tick_s = (i_hcnt == {CW{1'b0}}) && (i_vcnt == {CW{1'b0}});
    assign last_s = (idx_r == IDXW'(N_BALLS - 1));

    // One shared reflect unit per axis, fed by the ball selected by idx_r.
    ball_axis_step #(.CW(CW), .VW(VW), .LIM(LIM_X)) u_step_x (
        .pos (wpos_x_r[idx_r]),
        .vel (wvel_x_r[idx_r]),
        .neg (rev_pend_r),
        .res (step_x_s)
    );

    ball_axis_step #(.CW(CW), .VW(VW), .LIM(LIM_Y)) u_step_y (
        .pos (wpos_y_r[idx_r]),
        .vel (wvel_y_r[idx_r]),
        .neg (rev_pend_r),
        .res (step_y_s)
    );

    // Updater state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Updater next-state: ticks are only honoured from IDLE and when not paused.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (tick_s && !i_pause) begin
                    state_s = UPDATE;
                end else begin
                    state_s = IDLE;
                end
            end
            UPDATE: begin
                if (last_s) begin
                    state_s = COMMIT;
                end else begin
                    state_s = UPDATE;
                end
            end
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Working/display ball state, reverse request and bounce reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BALLS; i++) begin
                wpos_x_r[i] <= CW'(i * SX);
                wpos_y_r[i] <= CW'(i * SY);
                wvel_x_r[i] <= VW'(DX0 + i);
                wvel_y_r[i] <= VW'(DY0 + i);
                dpos_x_r[i] <= CW'(i * SX);
                dpos_y_r[i] <= CW'(i * SY);
            end
            idx_r        <= '0;
            rev_pend_r   <= 1'b0;
            bounce_acc_r <= 1'b0;
            bounce_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            bounce_r <= 1'b0;
            busy_r   <= (state_s != IDLE);
            // A reverse landing on the COMMIT clock is kept for the next frame.
            if (i_reverse) begin
                rev_pend_r <= 1'b1;
            end else if (state_r == COMMIT) begin
                rev_pend_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    idx_r        <= '0;
                    bounce_acc_r <= 1'b0;
                end
                UPDATE: begin
                    wpos_x_r[idx_r] <= step_x_s.pos[CW-1:0];
                    wvel_x_r[idx_r] <= step_x_s.vel[VW-1:0];
                    wpos_y_r[idx_r] <= step_y_s.pos[CW-1:0];
                    wvel_y_r[idx_r] <= step_y_s.vel[VW-1:0];
                    bounce_acc_r    <= bounce_acc_r | step_x_s.hit | step_y_s.hit;
                    idx_r           <= last_s ? '0 : idx_r + IDXW'(1);
                end
                COMMIT: begin
                    for (int i = 0; i < N_BALLS; i++) begin
                        dpos_x_r[i] <= wpos_x_r[i];
                        dpos_y_r[i] <= wpos_y_r[i];
                    end
                    bounce_r <= bounce_acc_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    // Per-ball hit test; the modular subtraction makes pixels left/above a ball wrap large.
    always_comb begin
        for (int i = 0; i < N_BALLS; i++) begin
            hit_s[i] = ((i_hcnt - dpos_x_r[i]) < CW'(BALL_W)) &&
                       ((i_vcnt - dpos_y_r[i]) < CW'(BALL_H));
        end
    end

    // Priority pick of the lowest-index hit: scan downward so lower indices win.
    always_comb begin
        hit_any_s = 1'b0;
        hit_idx_s = '0;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                hit_any_s = 1'b1;
                hit_idx_s = IDXW'(i);
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    // Draw outputs registered one clock behind the pixel counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            draw_r     <= 1'b0;
            ball_idx_r <= '0;
        end else begin
            draw_r     <= hit_any_s;
            ball_idx_r <= hit_idx_s;
        end
    end

`ifdef BALL_BOUNCER_HITCNT_EN
    logic [15:0] hits_r;

    // Saturating reflection counter, X and Y reflections counted separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_r <= 16'd0;
        end else if (state_r == UPDATE) begin
            hits_r <= sat_add16(hits_r, {1'b0, step_x_s.hit} + {1'b0, step_y_s.hit});
        end else begin
            hits_r <= hits_r;
        end
    end

    assign o_hits = hits_r;
`endif

    assign o_draw     = draw_r;
    assign o_ball_idx = ball_idx_r;
    assign o_busy     = busy_r;
    assign o_bounce   = bounce_r;

endmodule
